// File: rtl/array_multiplier_pipe.sv
// rtl/array_multiplier_pipe.sv - pipelined partial-product array multiplier with valid/ready flow control
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   i_valid   operand beat valid
//   i_ready   block accepts an operand beat this cycle (global advance enable)
//   i_signed  1 = two's-complement operands, 0 = unsigned
//   i_tag     sideband tag carried with the operands
//   A, B      multiplicand / multiplier
//   o_valid   result beat valid
//   o_ready   downstream accepts the result beat
//   o_tag     tag of the current result beat
//   Z_final   exact 2*DATAWIDTH-bit product
//   o_count   result handshakes completed, modulo 2^16

module array_multiplier_pipe #(
    parameter int DATAWIDTH           = 8,
    parameter int NUM_PIPELINE_STAGES = 2,
    parameter int INSTANCE_ID         = 0,
    parameter int TAGWIDTH            = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic                     i_signed,
    input  logic [TAGWIDTH-1:0]      i_tag,
    input  logic [DATAWIDTH-1:0]     A,
    input  logic [DATAWIDTH-1:0]     B,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [TAGWIDTH-1:0]      o_tag,
    output logic [2*DATAWIDTH-1:0]   Z_final,
    output logic [15:0]              o_count
);

    localparam int PW   = 2 * DATAWIDTH;
    localparam int NS   = NUM_PIPELINE_STAGES;
    localparam int ROWS = (DATAWIDTH + NS - 1) / NS;

    if (DATAWIDTH < 2 || DATAWIDTH > 32 || NS < 1 || NS > DATAWIDTH ||
        TAGWIDTH < 1 || TAGWIDTH > 16 || INSTANCE_ID < 0) begin : g_bad_params
        $error("array_multiplier_pipe: illegal parameter combination");
    end

    // Register level 0 is the operand capture; levels 1..NS each add one
    // group of partial-product rows. Level NS drives the outputs, so a beat
    // captured at edge N is presented after edge N+NS.
    logic [PW-1:0]        r_a   [0:NS-1];  // multiplicand, already extended to PW bits
    logic [DATAWIDTH-1:0] r_b   [0:NS-1];
    logic                 r_sgn [0:NS-1];
    logic [PW-1:0]        r_acc [1:NS];    // running partial sum
    logic [TAGWIDTH-1:0]  r_tag [0:NS];
    logic                 r_vld [0:NS];
    logic [15:0]          r_count;

    logic [PW-1:0]        w_acc_in [0:NS-1];
    logic [PW-1:0]        w_sum    [0:NS-1];
    logic                 w_en;

    // Adds rows k*ROWS .. k*ROWS+ROWS-1 of the partial-product array to acc.
    // With a sign-extended multiplicand, the only signed correction needed is
    // that the multiplier's MSB carries weight -2^(DATAWIDTH-1), so that row
    // is subtracted instead of added. All arithmetic is modulo 2^PW, which is
    // exact because every product fits in PW bits.
    function automatic logic [PW-1:0] f_add_rows(
        input int                   k,
        input logic [PW-1:0]        acc,
        input logic [PW-1:0]        a_ext,
        input logic [DATAWIDTH-1:0] b,
        input logic                 sgn
    );
        logic [PW-1:0] sum;
        int            idx;
        sum = acc;
        for (int j = 0; j < ROWS; j++) begin
            idx = k * ROWS + j;
            if (idx < DATAWIDTH) begin
                if (b[idx]) begin
                    if (sgn && (idx == DATAWIDTH - 1)) begin
                        sum = sum - (a_ext << idx);
                    end else begin
                        sum = sum + (a_ext << idx);
                    end
                end
            end
        end
        return sum;
    endfunction

    // Single advance enable: everything moves when the output slot is empty
    // or being taken. A bubble at the last level therefore opens the pipe.
    assign w_en    = o_ready || !r_vld[NS];
    assign i_ready = w_en;

    always_comb begin
        w_acc_in[0] = '0;
        for (int k = 1; k < NS; k++) begin
            w_acc_in[k] = r_acc[k];
        end
    end

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            w_sum[k] = f_add_rows(k, w_acc_in[k], r_a[k], r_b[k], r_sgn[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= NS; k++) begin
                r_vld[k] <= 1'b0;
                r_tag[k] <= '0;
            end
            for (int k = 0; k < NS; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sgn[k] <= 1'b0;
            end
            for (int k = 1; k <= NS; k++) begin
                r_acc[k] <= '0;
            end
        end else if (w_en) begin
            // Capture level: data is loaded every advancing cycle; only the
            // valid bit decides whether it means anything downstream.
            r_vld[0] <= i_valid;
            r_tag[0] <= i_tag;
            r_sgn[0] <= i_signed;
            r_b[0]   <= B;
            r_a[0]   <= i_signed ? {{DATAWIDTH{A[DATAWIDTH-1]}}, A}
                                 : {{DATAWIDTH{1'b0}}, A};

            for (int k = 0; k < NS; k++) begin
                r_vld[k+1] <= r_vld[k];
                r_tag[k+1] <= r_tag[k];
                r_acc[k+1] <= w_sum[k];
            end
            for (int k = 1; k < NS; k++) begin
                r_a[k]   <= r_a[k-1];
                r_b[k]   <= r_b[k-1];
                r_sgn[k] <= r_sgn[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (r_vld[NS] && o_ready) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_valid = r_vld[NS];
    assign o_tag   = r_tag[NS];
    assign Z_final = r_acc[NS];
    assign o_count = r_count;

endmodule

// File: doc/array_multiplier_pipe.md
ARRAY_MULTIPLIER_PIPE -- requirements
Module: array_multiplier_pipe

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 SHALL have parameter NUM_PIPELINE_STAGES, default 2: register stages from operand capture to Z_final, legal range 1..DATAWIDTH.
REQ-003 SHALL have parameter INSTANCE_ID, default 0: identifier with no functional effect; carried for tooling.
REQ-004 SHALL have parameter TAGWIDTH, default 4: width of the sideband tag, legal range 1..16.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous assertion, active-low.
REQ-007 SHALL have port i_valid  input  1  operand beat valid.
REQ-008 SHALL have port i_ready  output  1  block accepts an operand beat this cycle.
REQ-009 SHALL have port i_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port i_tag  input  TAGWIDTH  sideband tag travelling with the operands.
REQ-011 SHALL have port A  input  DATAWIDTH  multiplicand.
REQ-012 SHALL have port B  input  DATAWIDTH  multiplier.
REQ-013 SHALL have port o_valid  output  1  result beat valid.
REQ-014 SHALL have port o_ready  input  1  downstream accepts the result beat.
REQ-015 SHALL have port o_tag  output  TAGWIDTH  tag of the current result beat.
REQ-016 SHALL have port Z_final  output  2*DATAWIDTH  product.
REQ-017 SHALL have port o_count  output  16  number of result handshakes completed, modulo 2^16.

Function
REQ-018 SHALL capture a beat when i_valid && i_ready are both high at a rising edge; SHALL capture A, B, i_signed and i_tag together.
REQ-019 SHALL compute Z_final as the exact 2*DATAWIDTH-bit product: unsigned when the beat's i_signed = 0, two's-complement when 1; no truncation or saturation.
REQ-020 SHALL handle signed corner cases exactly, e.g. min*min = 2^(2*DATAWIDTH-2) and -1*-1 = 1.
REQ-021 SHALL implement the product as partial-product rows, with ceil(DATAWIDTH/NUM_PIPELINE_STAGES) rows summed per stage and a register at the end of each stage.
REQ-022 SHALL carry valid, signed mode and tag in lock-step with the data of each stage.
REQ-023 SHALL, with o_ready held high, present the result of a beat accepted at edge N with o_valid = 1 after edge N+NUM_PIPELINE_STAGES.
REQ-024 SHALL accept one beat per cycle with o_ready high; throughput SHALL be 1 result/cycle.
REQ-025 SHALL use a single global advance enable en = o_ready || !o_valid; all stages advance only when en = 1.
REQ-026 SHALL drive i_ready = en combinationally; i_ready SHALL NOT depend on i_valid.
REQ-027 SHALL hold o_valid, Z_final and o_tag stable while o_valid = 1 and o_ready = 0; no beat lost or duplicated.
REQ-028 SHALL propagate empty stages (bubbles) as valid = 0 without collapsing them; a bubble at the last stage makes en = 1.
REQ-029 SHALL increment o_count by 1 on each edge where o_valid && o_ready, wrapping 0xFFFF -> 0x0000.
REQ-030 SHALL let data-path registers of invalid stages hold any value; valid bits SHALL be exact.

Reset
REQ-031 SHALL, while rst = 0, force every stage valid bit to 0 and o_count to 0 asynchronously; o_valid = 0 and i_ready = 1 during reset.
REQ-032 SHALL clear Z_final and o_tag to 0 on reset.
REQ-033 SHALL discard in-flight beats when reset is asserted mid-operation; no result from before reset SHALL appear after deassertion.
REQ-034 SHALL accept a beat on the first rising edge after rst deasserts.

Verification (DATAWIDTH=8, NUM_PIPELINE_STAGES=2, TAGWIDTH=4)
REQ-035 SHALL cover unsigned: A=0xFF, B=0xFF, i_signed=0, tag=0x3 at edge 0 -> o_valid after edge 2, Z_final=0xFE01, o_tag=0x3, o_count=1 after the handshake.
REQ-036 SHALL cover signed: A=0x80, B=0x80 -> 0x4000; A=0xFF, B=0x01 -> 0xFFFF; A=0xFF, B=0xFF -> 0x0001; issued back-to-back, results on consecutive cycles.
REQ-037 SHALL cover mixed-mode streaming: alternate i_signed 0/1 with A=0xFF, B=0x02 -> results 0x01FE, 0xFFFE in order, tags preserved.
REQ-038 SHALL cover backpressure: 3 beats in flight, o_ready=0 for 4 cycles -> i_ready=0 while the output is occupied, Z_final/o_tag stable, then 3 results in order once o_ready=1, o_count +3.
REQ-039 SHALL cover reset mid-operation: 2 beats in flight, rst=0 for 1 cycle -> o_valid=0, o_count=0, no stale result afterwards; a new beat 5*7 -> 0x0023 two edges later.
REQ-040 SHALL cover counter wrap: force 65536 handshakes -> o_count returns to 0x0000.
